// File: rtl/control_fsm_param.sv
// control_fsm_param: parametrised multi-cycle controller for the 16-bit datapath.
// Decodes opCode1/opCode2, sequences fetch/decode/execute/write-back strobes,
// flags undefined opcodes and counts retired instructions.
// Optional feature macro: CTRL_STALL_EN (adds the stall port that freezes the FSM).
module control_fsm_param #(
  parameter int FETCH_LAT = 1,
  parameter int LOAD_LAT  = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opCode1,
  input  logic [3:0]       opCode2,
  input  logic [3:0]       conditionCode,
  input  logic [3:0]       shiftAmtIn,
  input  logic [7:0]       PSR,
`ifdef CTRL_STALL_EN
  input  logic             stall,
`endif
  output logic             storeReg,
  output logic             JmpEN,
  output logic             BranchEN,
  output logic             JALEN,
  output logic             PCEN,
  output logic             resultEN,
  output logic             immediateRegEN,
  output logic             wren_a,
  output logic             wren_b,
  output logic             nextInstruction,
  output logic             PSREN,
  output logic             regWriteEN,
  output logic             PCinstruction,
  output logic             zeroExtend,
  output logic             SrcB,
  output logic             updateAddress,
  output logic             writeData,
  output logic [3:0]       shifterControl,
  output logic [3:0]       ALUcontrol,
  output logic [1:0]       result,
  output logic [3:0]       shiftAmtOut,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [4:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR,
    S_RTYPEEX, S_RTYPEWR, S_ITYPEEX, S_ITYPEWR, S_SHIFTEX, S_SHIFTWR,
    S_BCONDEX, S_JALEX, S_JALWR, S_JCONDEX
  } state_t;

  localparam logic [3:0] FLAT_C = 4'(FETCH_LAT);
  localparam logic [3:0] LLAT_C = 4'(LOAD_LAT);

  state_t           state_r, state_next_s;
  logic [3:0]       wcnt_r, wcnt_next_s;
  logic [CNT_W-1:0] count_r;
  logic             freeze_s, active_s;
  logic             illegal_op1_s, illegal_op2_s, ze_op1_s, pass_s;
  logic             unused_psr_s;

  // Branch/jump condition evaluated against the PSR flags.
  function automatic logic cond_pass(input logic [3:0] cc, input logic [7:0] psr);
    logic z, c, n, f, l;
    z = psr[4]; c = psr[3]; n = psr[2]; f = psr[1]; l = psr[0];
    case (cc)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = l;
      4'h5: cond_pass = ~l;
      4'h6: cond_pass = f;
      4'h7: cond_pass = ~f;
      4'h8: cond_pass = n;
      4'h9: cond_pass = ~n;
      4'ha: cond_pass = ~z & ~l;
      4'hb: cond_pass = z | l;
      4'hc: cond_pass = ~f & ~z;
      4'hd: cond_pass = z | f;
      4'he: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

`ifdef CTRL_STALL_EN
  assign freeze_s = stall;
`else
  assign freeze_s = 1'b0;
`endif

  assign active_s      = reset & ~freeze_s;
  assign illegal_op1_s = (opCode1 == 4'h6) | (opCode1 == 4'h7) |
                         (opCode1 == 4'ha) | (opCode1 == 4'he);
  assign illegal_op2_s = ~((opCode2 == 4'h0) | (opCode2 == 4'h4) |
                           (opCode2 == 4'h8) | (opCode2 == 4'hc));
  assign ze_op1_s      = (opCode1 == 4'h1) | (opCode1 == 4'h2) |
                         (opCode1 == 4'h3) | (opCode1 == 4'hd);
  assign pass_s        = cond_pass(conditionCode, PSR);
  assign unused_psr_s  = ^PSR[7:5];
  assign shiftAmtOut   = shiftAmtIn;
  assign retired_count = count_r;

  // State, wait counter and retired counter; stall holds everything, reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_FETCH;
      wcnt_r  <= 4'd0;
      count_r <= '0;
    end else if (freeze_s) begin
      state_r <= state_r;
      wcnt_r  <= wcnt_r;
      count_r <= count_r;
    end else begin
      state_r <= state_next_s;
      wcnt_r  <= wcnt_next_s;
      if (state_next_s == S_FETCH) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state decode and wait-counter sequencing.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:   state_next_s = S_FWAIT;
      S_FWAIT:   state_next_s = (wcnt_r == FLAT_C) ? S_DECODE : S_FWAIT;
      S_DECODE: begin
        case (opCode1)
          4'h0:                      state_next_s = S_RTYPEEX;
          4'h4:                      state_next_s = S_MEMADR;
          4'h8, 4'hf:                state_next_s = S_SHIFTEX;
          4'h1, 4'h2, 4'h3, 4'h5,
          4'h9, 4'hb, 4'hd:          state_next_s = S_ITYPEEX;
          4'hc:                      state_next_s = S_BCONDEX;
          default:                   state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (opCode2)
          4'h0:    state_next_s = S_LBRD;
          4'h4:    state_next_s = S_SBWR;
          4'h8:    state_next_s = S_JALEX;
          4'hc:    state_next_s = S_JCONDEX;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_LBRD:    state_next_s = S_LBWR;
      S_LBWR:    state_next_s = (wcnt_r == LLAT_C) ? S_FETCH : S_LBWR;
      S_RTYPEEX: state_next_s = S_RTYPEWR;
      S_ITYPEEX: state_next_s = S_ITYPEWR;
      S_SHIFTEX: state_next_s = S_SHIFTWR;
      S_JALEX:   state_next_s = S_JALWR;
      default:   state_next_s = S_FETCH;
    endcase

    // Wait counter starts at 1 on entry so a state with latency N lasts N cycles.
    if ((state_next_s == S_FWAIT || state_next_s == S_LBWR) && state_next_s != state_r) begin
      wcnt_next_s = 4'd1;
    end else if (state_next_s == state_r) begin
      wcnt_next_s = wcnt_r + 4'd1;
    end else begin
      wcnt_next_s = 4'd0;
    end
  end

  // Per-state strobes and selects; everything held at defaults in reset or stall.
  always_comb begin
    storeReg = 1'b0; JmpEN = 1'b0; BranchEN = 1'b0; JALEN = 1'b0;
    PCEN = 1'b0; resultEN = 1'b0; immediateRegEN = 1'b0; wren_a = 1'b0;
    wren_b = 1'b0; nextInstruction = 1'b0; PSREN = 1'b0; regWriteEN = 1'b0;
    PCinstruction = 1'b0; zeroExtend = 1'b1; SrcB = 1'b1; updateAddress = 1'b1;
    writeData = 1'b1; shifterControl = 4'h0; ALUcontrol = 4'h5; result = 2'h1;
    illegal = 1'b0; retire = 1'b0;
    if (active_s) begin
      retire = (state_next_s == S_FETCH);
      case (state_r)
        S_FETCH: begin
          nextInstruction = 1'b1; PCinstruction = 1'b1; PCEN = 1'b1;
        end
        S_FWAIT:  nextInstruction = 1'b1;
        S_DECODE: begin
          SrcB = 1'b0; immediateRegEN = 1'b1;
          zeroExtend = opCode2[3] & ze_op1_s;
          illegal = illegal_op1_s;
        end
        S_MEMADR: illegal = illegal_op2_s;
        S_LBRD:   updateAddress = 1'b0;
        S_LBWR: begin
          writeData = 1'b0; regWriteEN = 1'b1;
        end
        S_SBWR: begin
          storeReg = 1'b1; updateAddress = 1'b0; wren_a = 1'b1;
        end
        S_RTYPEEX: begin
          ALUcontrol = opCode2;
          PSREN = (opCode2 != 4'h0); resultEN = (opCode2 != 4'h0);
        end
        S_RTYPEWR: regWriteEN = (opCode2 != 4'h0) && (opCode2 != 4'hb);
        S_ITYPEEX: begin
          ALUcontrol = opCode1; SrcB = 1'b0; PSREN = 1'b1; resultEN = 1'b1;
        end
        S_ITYPEWR: regWriteEN = (opCode1 != 4'hb);
        S_SHIFTEX: begin
          result = 2'h0; resultEN = 1'b1;
          if (opCode1 == 4'hf) begin
            SrcB = 1'b0; shifterControl = opCode1;
          end else begin
            SrcB = (opCode2 == 4'h4); shifterControl = opCode2;
          end
        end
        S_SHIFTWR: regWriteEN = 1'b1;
        S_BCONDEX: begin
          BranchEN = pass_s; PCinstruction = 1'b1; PCEN = 1'b1;
          SrcB = 1'b0; zeroExtend = 1'b0;
        end
        S_JALEX: begin
          JALEN = 1'b1; PCinstruction = 1'b1; PCEN = 1'b1;
          result = 2'h3; resultEN = 1'b1;
        end
        S_JALWR:   regWriteEN = 1'b1;
        S_JCONDEX: begin
          JmpEN = pass_s; PCinstruction = 1'b1; PCEN = 1'b1;
        end
        default:   illegal = 1'b0;
      endcase
    end else begin
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm_param.sv
// Self-checking bench for control_fsm_param: two instances (default parameters,
// and FETCH_LAT=3/LOAD_LAT=4/CNT_W=2) checked cycle by cycle against a
// per-instruction reference model built from the instruction-class rules.
module tb_control_fsm_param;

  typedef struct packed {
    logic storeReg, JmpEN, BranchEN, JALEN, PCEN, resultEN, immediateRegEN;
    logic wren_a, wren_b, nextInstruction, PSREN, regWriteEN, PCinstruction;
    logic zeroExtend, SrcB, updateAddress, writeData;
    logic [3:0] shifterControl;
    logic [3:0] ALUcontrol;
    logic [1:0] result;
    logic illegal, retire;
  } outs_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [3:0] op1_a, op2_a, cc_a, sh_a, op1_b, op2_b, cc_b, sh_b;
  logic [7:0] psr_a, psr_b;
  wire  [28:0] oa_v, ob_v;
  wire  [3:0]  sha_o, shb_o;
  wire  [15:0] cnt_a;
  wire  [1:0]  cnt_b;

  int    checks = 0, errors = 0;
  int    nret_a = 0, nret_b = 0;
  int    rwe_seen, first_cnt;
  outs_t exp_q[$];

  control_fsm_param dut_a (
    .clk(clk), .reset(reset_a), .opCode1(op1_a), .opCode2(op2_a),
    .conditionCode(cc_a), .shiftAmtIn(sh_a), .PSR(psr_a),
`ifdef CTRL_STALL_EN
    .stall(1'b0),
`endif
    .storeReg(oa_v[28]), .JmpEN(oa_v[27]), .BranchEN(oa_v[26]), .JALEN(oa_v[25]),
    .PCEN(oa_v[24]), .resultEN(oa_v[23]), .immediateRegEN(oa_v[22]), .wren_a(oa_v[21]),
    .wren_b(oa_v[20]), .nextInstruction(oa_v[19]), .PSREN(oa_v[18]), .regWriteEN(oa_v[17]),
    .PCinstruction(oa_v[16]), .zeroExtend(oa_v[15]), .SrcB(oa_v[14]), .updateAddress(oa_v[13]),
    .writeData(oa_v[12]), .shifterControl(oa_v[11:8]), .ALUcontrol(oa_v[7:4]),
    .result(oa_v[3:2]), .shiftAmtOut(sha_o), .illegal(oa_v[1]), .retire(oa_v[0]),
    .retired_count(cnt_a)
  );

  control_fsm_param #(.FETCH_LAT(3), .LOAD_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset_b), .opCode1(op1_b), .opCode2(op2_b),
    .conditionCode(cc_b), .shiftAmtIn(sh_b), .PSR(psr_b),
`ifdef CTRL_STALL_EN
    .stall(1'b0),
`endif
    .storeReg(ob_v[28]), .JmpEN(ob_v[27]), .BranchEN(ob_v[26]), .JALEN(ob_v[25]),
    .PCEN(ob_v[24]), .resultEN(ob_v[23]), .immediateRegEN(ob_v[22]), .wren_a(ob_v[21]),
    .wren_b(ob_v[20]), .nextInstruction(ob_v[19]), .PSREN(ob_v[18]), .regWriteEN(ob_v[17]),
    .PCinstruction(ob_v[16]), .zeroExtend(ob_v[15]), .SrcB(ob_v[14]), .updateAddress(ob_v[13]),
    .writeData(ob_v[12]), .shifterControl(ob_v[11:8]), .ALUcontrol(ob_v[7:4]),
    .result(ob_v[3:2]), .shiftAmtOut(shb_o), .illegal(ob_v[1]), .retire(ob_v[0]),
    .retired_count(cnt_b)
  );

  function automatic outs_t dflt();
    outs_t o;
    o = '0;
    o.zeroExtend = 1'b1; o.SrcB = 1'b1; o.updateAddress = 1'b1; o.writeData = 1'b1;
    o.ALUcontrol = 4'h5; o.result = 2'h1;
    return o;
  endfunction

  function automatic logic pass_f(input logic [3:0] cc, input logic [7:0] psr);
    logic z, c, n, f, l;
    z = psr[4]; c = psr[3]; n = psr[2]; f = psr[1]; l = psr[0];
    case (cc)
      4'h0: return z;       4'h1: return !z;
      4'h2: return c;       4'h3: return !c;
      4'h4: return l;       4'h5: return !l;
      4'h6: return f;       4'h7: return !f;
      4'h8: return n;       4'h9: return !n;
      4'ha: return !z && !l; 4'hb: return z || l;
      4'hc: return !f && !z; 4'hd: return z || f;
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one whole instruction, first cycle = fetch.
  task automatic build(input logic [3:0] op1, op2, cc, input logic [7:0] psr,
                       input int flat, input int llat);
    outs_t o;
    exp_q.delete();
    o = dflt(); o.nextInstruction = 1; o.PCinstruction = 1; o.PCEN = 1; exp_q.push_back(o);
    for (int i = 0; i < flat; i++) begin
      o = dflt(); o.nextInstruction = 1; exp_q.push_back(o);
    end
    o = dflt(); o.SrcB = 0; o.immediateRegEN = 1;
    o.zeroExtend = op2[3] && (op1 == 4'h1 || op1 == 4'h2 || op1 == 4'h3 || op1 == 4'hd);
    if (op1 == 4'h6 || op1 == 4'h7 || op1 == 4'ha || op1 == 4'he) begin
      o.illegal = 1; o.retire = 1; exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    if (op1 == 4'h0) begin
      o = dflt(); o.ALUcontrol = op2; o.PSREN = (op2 != 0); o.resultEN = (op2 != 0);
      exp_q.push_back(o);
      o = dflt(); o.regWriteEN = !(op2 == 4'h0 || op2 == 4'hb); o.retire = 1; exp_q.push_back(o);
    end else if (op1 == 4'h4) begin
      o = dflt();
      if (!(op2 == 4'h0 || op2 == 4'h4 || op2 == 4'h8 || op2 == 4'hc)) begin
        o.illegal = 1; o.retire = 1; exp_q.push_back(o);
        return;
      end
      exp_q.push_back(o);
      if (op2 == 4'h0) begin
        o = dflt(); o.updateAddress = 0; exp_q.push_back(o);
        for (int i = 0; i < llat; i++) begin
          o = dflt(); o.writeData = 0; o.regWriteEN = 1; o.retire = (i == llat - 1);
          exp_q.push_back(o);
        end
      end else if (op2 == 4'h4) begin
        o = dflt(); o.storeReg = 1; o.updateAddress = 0; o.wren_a = 1; o.retire = 1;
        exp_q.push_back(o);
      end else if (op2 == 4'h8) begin
        o = dflt(); o.JALEN = 1; o.PCinstruction = 1; o.PCEN = 1; o.result = 2'h3; o.resultEN = 1;
        exp_q.push_back(o);
        o = dflt(); o.regWriteEN = 1; o.retire = 1; exp_q.push_back(o);
      end else begin
        o = dflt(); o.JmpEN = pass_f(cc, psr); o.PCinstruction = 1; o.PCEN = 1; o.retire = 1;
        exp_q.push_back(o);
      end
    end else if (op1 == 4'h8 || op1 == 4'hf) begin
      o = dflt(); o.result = 2'h0; o.resultEN = 1;
      o.SrcB = (op1 == 4'hf) ? 1'b0 : (op2 == 4'h4);
      o.shifterControl = (op1 == 4'hf) ? op1 : op2;
      exp_q.push_back(o);
      o = dflt(); o.regWriteEN = 1; o.retire = 1; exp_q.push_back(o);
    end else if (op1 == 4'hc) begin
      o = dflt(); o.BranchEN = pass_f(cc, psr); o.PCinstruction = 1; o.PCEN = 1;
      o.SrcB = 0; o.zeroExtend = 0; o.retire = 1; exp_q.push_back(o);
    end else begin
      o = dflt(); o.ALUcontrol = op1; o.SrcB = 0; o.PSREN = 1; o.resultEN = 1; exp_q.push_back(o);
      o = dflt(); o.regWriteEN = (op1 != 4'hb); o.retire = 1; exp_q.push_back(o);
    end
  endtask

  task automatic drive(input bit b, input logic [3:0] op1, op2, cc, sh, input logic [7:0] psr);
    if (b) begin
      op1_b = op1; op2_b = op2; cc_b = cc; sh_b = sh; psr_b = psr;
    end else begin
      op1_a = op1; op2_a = op2; cc_a = cc; sh_a = sh; psr_a = psr;
    end
  endtask

  task automatic do_reset(input bit b);
    @(negedge clk);
    if (b) reset_b = 1'b0; else reset_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(b, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
      #1;
      check("reset_outs", b ? ob_v : oa_v, dflt());
      check("reset_count", b ? {14'd0, cnt_b} : cnt_a, 64'd0);
    end
    @(posedge clk);
    #1;
    if (b) begin reset_b = 1'b1; nret_b = 0; end
    else begin reset_a = 1'b1; nret_a = 0; end
  endtask

  task automatic run_instr(input bit b, input logic [3:0] op1, op2, cc, input logic [7:0] psr);
    logic [3:0]  sh;
    logic [28:0] got;
    logic [15:0] cnt;
    int          expc;
    sh = 4'($urandom);
    build(op1, op2, cc, psr, b ? 3 : 1, b ? 4 : 2);
    rwe_seen = 0;
    expc = b ? (nret_b % 4) : (nret_a % 65536);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      drive(b, op1, op2, cc, sh, psr);
      #1;
      got = b ? ob_v : oa_v;
      cnt = b ? {14'd0, cnt_b} : cnt_a;
      if (i == 0) first_cnt = int'(cnt);
      check("outputs", got, exp_q[i]);
      check("shiftAmtOut", b ? shb_o : sha_o, sh);
      check("retired_count", cnt, expc);
      if (got[17]) rwe_seen++;
    end
    if (b) nret_b++; else nret_a++;
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // Default-parameter instance: directed cases first.
    do_reset(1'b0);
    run_instr(1'b0, 4'h5, 4'($urandom), 4'($urandom), 8'($urandom));   // ADDI
    check("addi_len", exp_q.size(), 64'd5);
    check("addi_alu", exp_q[3].ALUcontrol, 64'h5);
    check("addi_psren", exp_q[3].PSREN, 64'd1);
    check("addi_rwe_c5", exp_q[4].regWriteEN & exp_q[4].retire, 64'd1);
    run_instr(1'b0, 4'hc, 4'h0, 4'h0, 8'h10);                          // BCOND taken
    check("count_after_addi", first_cnt, 64'd1);
    check("bcond_taken", exp_q[3].BranchEN & exp_q[3].PCEN, 64'd1);
    run_instr(1'b0, 4'hc, 4'h0, 4'h0, 8'h00);                          // BCOND not taken
    check("bcond_not_taken", {exp_q[3].BranchEN, exp_q[3].PCEN}, 64'b01);
    run_instr(1'b0, 4'h6, 4'h0, 4'h0, 8'h00);                          // illegal opCode1
    check("illegal_decode", {exp_q.size(), exp_q[2].illegal, exp_q[2].retire}, {32'd3, 2'b11});
    run_instr(1'b0, 4'h4, 4'h1, 4'h0, 8'h00);                          // illegal opCode2
    check("illegal_memadr", exp_q[3].illegal, 64'd1);
    run_instr(1'b0, 4'h4, 4'h8, 4'h0, 8'h00);                          // JAL
    for (int k = 0; k < 60; k++)
      run_instr(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));

    // Mid-instruction reset: no retire, count back to zero.
    @(negedge clk); @(negedge clk);
    do_reset(1'b0);
    run_instr(1'b0, 4'h0, 4'h3, 4'h0, 8'h00);

    // FETCH_LAT=3, LOAD_LAT=4, CNT_W=2 instance.
    do_reset(1'b1);
    run_instr(1'b1, 4'h4, 4'h0, 4'h0, 8'h00);                          // LB
    check("lb_len", exp_q.size(), 64'd11);
    check("lb_rwe_cycles", rwe_seen, 64'd4);
    for (int k = 0; k < 4; k++)
      run_instr(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
    run_instr(1'b1, 4'h1, 4'h8, 4'h0, 8'h00);
    check("count_wrap_5", first_cnt, 64'd1);
    for (int k = 0; k < 40; k++)
      run_instr(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
